// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe
//   MEM->WB pipeline register with a configurable number of stages (DEPTH).
//   Each stage carries a valid bit, the WB control bits
//   {PctoReg, MemtoReg, RegWrite} and the payload (PC+4, DM read data,
//   ALU result, destination register). Supports hold (stall) and
//   invalidate (flush). Flush takes priority over stall, and stall takes
//   priority over advance. A stage whose valid bit is 0 always carries
//   all-zero control, so a bubble can never write the register file.
//
// Optional feature (macro MEM_WB_STAT_EN):
//   Defined   - builds saturating stall/flush cycle counters.
//   Undefined - the counters are not built; stall_cnt/flush_cnt read 0.
//
// Ports
//   clock       in   1       rising-edge clock
//   reset       in   1       asynchronous active-high reset
//   stall       in   1       hold every stage this cycle
//   flush       in   1       invalidate every stage this cycle
//   in_valid    in   1       incoming instruction is real (0 = bubble)
//   in_ctrl     in   CTRL_W  WB control from EX/MEM (bit0 = RegWrite)
//   in_pc_add   in   DATA_W  PC+4
//   in_dm       in   DATA_W  data-memory read data
//   in_alu      in   DATA_W  ALU result
//   in_rd       in   REG_AW  destination register
//   out_*       out          last-stage copy of the fields above
//   stall_cnt   out  STAT_W  stall cycles seen (saturating)
//   flush_cnt   out  STAT_W  flush cycles seen (saturating)
// -----------------------------------------------------------------------------
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3,
  parameter int DEPTH  = 1,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pc_add,
  input  logic [DATA_W-1:0] in_dm,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc_add,
  output logic [DATA_W-1:0] out_dm,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_AW-1:0] out_rd,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc_add;
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] rd;
  } stage_t;

  stage_t stage_q [DEPTH];
  stage_t stage_in;

  // Entry value for stage 0. Control is masked by in_valid so a bubble
  // enters with zero control; the payload is loaded regardless.
  always_comb begin
    // NOTE: give every combinational output a value on every path (here a
    // default first) so no latch is inferred.
    stage_in        = '0;
    stage_in.valid  = in_valid;
    stage_in.ctrl   = in_valid ? in_ctrl : '0;
    stage_in.pc_add = in_pc_add;
    stage_in.dm     = in_dm;
    stage_in.alu    = in_alu;
    stage_in.rd     = in_rd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this stage array is a bank of pipeline flops, not a RAM, so
      // clearing every entry on reset is cheap and required here.
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (flush) begin
      // Invalidate only; payload fields keep their values.
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k].valid <= 1'b0;
        stage_q[k].ctrl  <= '0;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what turns this loop into a shift.
      stage_q[0] <= stage_in;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign out_valid  = stage_q[DEPTH-1].valid;
  assign out_ctrl   = stage_q[DEPTH-1].ctrl;
  assign out_pc_add = stage_q[DEPTH-1].pc_add;
  assign out_dm     = stage_q[DEPTH-1].dm;
  assign out_alu    = stage_q[DEPTH-1].alu;
  assign out_rd     = stage_q[DEPTH-1].rd;

`ifdef MEM_WB_STAT_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  // Counters stop at all-ones instead of wrapping. A cycle with both stall
  // and flush counts as a flush only, matching the datapath priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      end
      if (stall && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe
//   Directed bench for mem_wb_pipe. Two instances share one stimulus stream:
//   u_d1 (DEPTH=1, STAT_W=16) and u_d3 (DEPTH=3, STAT_W=4). Counter
//   expectations follow whether MEM_WB_STAT_EN is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_wb_pipe;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_ctrl;
  logic [31:0] in_pc_add;
  logic [31:0] in_dm;
  logic [31:0] in_alu;
  logic [4:0]  in_rd;

  logic        o1_valid, o3_valid;
  logic [2:0]  o1_ctrl, o3_ctrl;
  logic [31:0] o1_pc_add, o1_dm, o1_alu, o3_pc_add, o3_dm, o3_alu;
  logic [4:0]  o1_rd, o3_rd;
  logic [15:0] o1_stall_cnt, o1_flush_cnt;
  logic [3:0]  o3_stall_cnt, o3_flush_cnt;

  // {valid, ctrl, pc_add, dm, alu, rd}
  logic [104:0] o1_all, o3_all;
  assign o1_all = {o1_valid, o1_ctrl, o1_pc_add, o1_dm, o1_alu, o1_rd};
  assign o3_all = {o3_valid, o3_ctrl, o3_pc_add, o3_dm, o3_alu, o3_rd};

  int checks = 0;
  int errors = 0;

`ifdef MEM_WB_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .DEPTH(1), .STAT_W(16)) u_d1 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc_add(in_pc_add),
    .in_dm(in_dm), .in_alu(in_alu), .in_rd(in_rd),
    .out_valid(o1_valid), .out_ctrl(o1_ctrl), .out_pc_add(o1_pc_add),
    .out_dm(o1_dm), .out_alu(o1_alu), .out_rd(o1_rd),
    .stall_cnt(o1_stall_cnt), .flush_cnt(o1_flush_cnt)
  );

  mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .DEPTH(3), .STAT_W(4)) u_d3 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_pc_add(in_pc_add),
    .in_dm(in_dm), .in_alu(in_alu), .in_rd(in_rd),
    .out_valid(o3_valid), .out_ctrl(o3_ctrl), .out_pc_add(o3_pc_add),
    .out_dm(o3_dm), .out_alu(o3_alu), .out_rd(o3_rd),
    .stall_cnt(o3_stall_cnt), .flush_cnt(o3_flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] pc,
                       input logic [31:0] dm, input logic [31:0] alu, input logic [4:0] rd);
    in_valid  = v;
    in_ctrl   = c;
    in_pc_add = pc;
    in_dm     = dm;
    in_alu    = alu;
    in_rd     = rd;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Fill both pipes with real instructions so outputs are non-zero.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b011, $urandom, $urandom, $urandom | 32'h1, 5'd7);
      tick();
    end
    drive(1'b1, 3'b111, $urandom, $urandom, $urandom, 5'($urandom));
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (o1_all !== 105'd0) begin
      errors++;
      $display("FAIL reset_async_d1: got %h expected 0", o1_all);
    end
    checks++;
    if (o3_all !== 105'd0) begin
      errors++;
      $display("FAIL reset_async_d3: got %h expected 0", o3_all);
    end
    checks++;
    if ({o1_stall_cnt, o1_flush_cnt, o3_stall_cnt, o3_flush_cnt} !== 40'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h expected 0",
               {o1_stall_cnt, o1_flush_cnt, o3_stall_cnt, o3_flush_cnt});
    end
    @(negedge clock);
    reset = 1'b0;
    // In-flight instructions must be gone: bubbles only for DEPTH edges.
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o3_valid !== 1'b0 || o3_ctrl !== 3'b000) begin
        errors++;
        $display("FAIL reset_discard_d3[%0d]: got valid=%b ctrl=%b expected 0/000",
                 i, o3_valid, o3_ctrl);
      end
    end
  endtask

  task automatic test_depth1_pass();
    drive(1'b1, 3'b001, 32'h0000_0104, 32'h0000_BEEF, 32'h0000_00A5, 5'd9);
    tick();
    checks++;
    if (o1_all !== {1'b1, 3'b001, 32'h0000_0104, 32'h0000_BEEF, 32'h0000_00A5, 5'd9}) begin
      errors++;
      $display("FAIL depth1_pass: got %h expected valid=1 ctrl=001 alu=a5 rd=9", o1_all);
    end
    // Registered output: changing inputs between edges must not show through.
    drive(1'b0, 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    #2;
    checks++;
    if (o1_all !== {1'b1, 3'b001, 32'h0000_0104, 32'h0000_BEEF, 32'h0000_00A5, 5'd9}) begin
      errors++;
      $display("FAIL depth1_no_comb_path: got %h expected previous value held", o1_all);
    end
  endtask

  task automatic test_back_to_back();
    logic [104:0] a, b, c;
    a = {1'b1, 3'b001, 32'h0000_1004, 32'h1111_1111, 32'hAAAA_0001, 5'd1};
    b = {1'b1, 3'b011, 32'h0000_1008, 32'h2222_2222, 32'hAAAA_0002, 5'd2};
    c = {1'b1, 3'b101, 32'h0000_100C, 32'h3333_3333, 32'hAAAA_0003, 5'd3};
    drive(1'b1, 3'b001, 32'h0000_1004, 32'h1111_1111, 32'hAAAA_0001, 5'd1);
    tick();
    checks++;
    if (o1_all !== a) begin
      errors++;
      $display("FAIL b2b_d1_a: got %h expected %h", o1_all, a);
    end
    drive(1'b1, 3'b011, 32'h0000_1008, 32'h2222_2222, 32'hAAAA_0002, 5'd2);
    tick();
    checks++;
    if (o1_all !== b) begin
      errors++;
      $display("FAIL b2b_d1_b: got %h expected %h", o1_all, b);
    end
    drive(1'b1, 3'b101, 32'h0000_100C, 32'h3333_3333, 32'hAAAA_0003, 5'd3);
    tick();
    checks++;
    if (o3_all !== a) begin
      errors++;
      $display("FAIL b2b_d3_a: got %h expected %h", o3_all, a);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    checks++;
    if (o3_all !== b) begin
      errors++;
      $display("FAIL b2b_d3_b: got %h expected %h", o3_all, b);
    end
    tick();
    checks++;
    if (o3_all !== c) begin
      errors++;
      $display("FAIL b2b_d3_c: got %h expected %h", o3_all, c);
    end
  endtask

  task automatic test_depth3_latency();
    // Drain with zero bubbles.
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (3) tick();
    // Plain latency: pulse at edge 0, visible from edge 2.
    drive(1'b1, 3'b001, 32'h0, 32'h0, 32'h1234_5678, 5'd4);
    tick();                                   // edge 0
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();                                   // edge 1
    checks++;
    if (o3_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_d3_early: got valid=%b expected 0", o3_valid);
    end
    tick();                                   // edge 2
    checks++;
    if ({o3_valid, o3_ctrl, o3_alu} !== {1'b1, 3'b001, 32'h1234_5678}) begin
      errors++;
      $display("FAIL lat_d3_edge2: got valid=%b ctrl=%b alu=%h expected 1/001/12345678",
               o3_valid, o3_ctrl, o3_alu);
    end
    repeat (2) tick();
    // Stalled latency: pulse at edge 0, stall at edges 1..2, visible from edge 4.
    drive(1'b1, 3'b001, 32'h0, 32'h0, 32'h1234_5678, 5'd4);
    tick();                                   // edge 0
    stall = 1'b1;
    drive(1'b1, 3'b111, 32'h0, 32'h0, 32'h0000_FFFF, 5'd30); // must be dropped
    tick();                                   // edge 1
    tick();                                   // edge 2
    stall = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();                                   // edge 3
    checks++;
    if (o3_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_stall_edge3: got valid=%b expected 0", o3_valid);
    end
    tick();                                   // edge 4
    checks++;
    if ({o3_valid, o3_ctrl, o3_alu} !== {1'b1, 3'b001, 32'h1234_5678}) begin
      errors++;
      $display("FAIL lat_stall_edge4: got valid=%b ctrl=%b alu=%h expected 1/001/12345678",
               o3_valid, o3_ctrl, o3_alu);
    end
    tick();                                   // edge 5: input held during stall was dropped
    checks++;
    if ({o3_valid, o3_alu} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL lat_stall_dropped: got valid=%b alu=%h expected 0/00000000",
               o3_valid, o3_alu);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 3'b111, 32'h0000_0200, 32'h0000_0300, 32'h0000_0055, 5'd12);
    tick();
    checks++;
    if (o1_all !== {1'b0, 3'b000, 32'h0000_0200, 32'h0000_0300, 32'h0000_0055, 5'd12}) begin
      errors++;
      $display("FAIL bubble_d1: got %h expected valid=0 ctrl=000 payload loaded", o1_all);
    end
    repeat (2) tick();
    checks++;
    if (o3_all !== {1'b0, 3'b000, 32'h0000_0200, 32'h0000_0300, 32'h0000_0055, 5'd12}) begin
      errors++;
      $display("FAIL bubble_d3: got %h expected valid=0 ctrl=000 payload loaded", o3_all);
    end
  endtask

  task automatic test_flush_beats_stall();
    drive(1'b1, 3'b101, 32'h0000_0A04, 32'h0000_0B0B, 32'h0000_A5A5, 5'd17);
    tick();
    checks++;
    if ({o1_valid, o1_ctrl, o1_alu} !== {1'b1, 3'b101, 32'h0000_A5A5}) begin
      errors++;
      $display("FAIL flush_setup_d1: got valid=%b ctrl=%b alu=%h expected 1/101/0000a5a5",
               o1_valid, o1_ctrl, o1_alu);
    end
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 3'b111, 32'h0, 32'h0, 32'h0000_7777, 5'd3);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if (o1_all !== {1'b0, 3'b000, 32'h0000_0A04, 32'h0000_0B0B, 32'h0000_A5A5, 5'd17}) begin
      errors++;
      $display("FAIL flush_over_stall_d1: got %h expected valid=0 ctrl=000 alu=a5a5 kept",
               o1_all);
    end
    checks++;
    if ({o3_valid, o3_ctrl} !== 4'b0) begin
      errors++;
      $display("FAIL flush_over_stall_d3: got valid=%b ctrl=%b expected 0/000",
               o3_valid, o3_ctrl);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
  endtask

  task automatic test_stats();
    do_reset();
    stall = 1'b1;
    repeat (20) tick();
    stall = 1'b0;
    flush = 1'b1;
    repeat (3) tick();
    flush = 1'b0;
    tick();
    checks++;
    if (o3_stall_cnt !== (STAT_ON ? 4'd15 : 4'd0)) begin
      errors++;
      $display("FAIL stats_stall_sat_d3: got %0d expected %0d", o3_stall_cnt,
               STAT_ON ? 15 : 0);
    end
    checks++;
    if (o1_stall_cnt !== (STAT_ON ? 16'd20 : 16'd0)) begin
      errors++;
      $display("FAIL stats_stall_d1: got %0d expected %0d", o1_stall_cnt, STAT_ON ? 20 : 0);
    end
    checks++;
    if ({o3_flush_cnt, o1_flush_cnt} !== (STAT_ON ? {4'd3, 16'd3} : 20'd0)) begin
      errors++;
      $display("FAIL stats_flush: got d3=%0d d1=%0d expected %0d", o3_flush_cnt,
               o1_flush_cnt, STAT_ON ? 3 : 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    test_reset();
    test_depth1_pass();
    test_back_to_back();
    test_depth3_latency();
    test_bubble();
    test_flush_beats_stall();
    test_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
